// File: rtl/sine_scroll_if.sv
// Frame/pixel bundle between the video timing source and the sine-scroll controller.
interface sine_scroll_if;
    logic       frame_start;
    logic       pix_valid;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       pause;
    logic [1:0] speed;
    logic [5:0] x_out;
    logic [4:0] y_out;
    logic       layer_en;
    logic [5:0] scroll_x;
    logic       dir_up;

    modport master (
        output frame_start, pix_valid, hpos, vpos, pause, speed,
        input  x_out, y_out, layer_en, scroll_x, dir_up
    );

    modport slave (
        input  frame_start, pix_valid, hpos, vpos, pause, speed,
        output x_out, y_out, layer_en, scroll_x, dir_up
    );
endinterface

// File: rtl/sine_scroll_ctrl.sv
// Per-frame horizontal scroll plus bouncing vertical band; maps each pixel to a
// cell coordinate of the sine layer with one cycle of latency.
module sine_scroll_ctrl #(
    parameter int Y_MAX = 38
) (
    input  logic          clk,
    input  logic          rst,
    sine_scroll_if.slave  bus
);
    localparam logic [5:0] Y_MAX_C  = 6'(Y_MAX);
    localparam logic [6:0] BAND_H_C = 7'd22;

    typedef enum logic {DOWN = 1'b0, UP = 1'b1} dir_t;

    dir_t       state_r, state_s;
    logic [5:0] y_off_r, y_off_s;
    logic [5:0] scroll_x_r, scroll_x_s;
    logic [5:0] x_out_r, x_out_s;
    logic [4:0] y_out_r, y_out_s;
    logic       layer_en_r, layer_en_s;

    logic [5:0] cell_x_s;
    logic [5:0] cell_y_s;
    logic [6:0] rel_s;
    logic       inside_s;
    logic       unused_s;

    // Sub-cell bits and the top position bit carry no meaning for the layer.
    assign unused_s = ^{bus.hpos[9], bus.hpos[2:0], bus.vpos[9], bus.vpos[2:0]};

    // Animation next-state: scroll advance and vertical bounce FSM.
    always_comb begin
        state_s    = state_r;
        y_off_s    = y_off_r;
        scroll_x_s = scroll_x_r;
        if (bus.frame_start && !bus.pause) begin
            scroll_x_s = scroll_x_r + {4'd0, bus.speed};
            case (state_r)
                DOWN: begin
                    if (Y_MAX_C == 6'd0) begin
                        // A zero-height travel range would underflow on the turn.
                        y_off_s = 6'd0;
                        state_s = DOWN;
                    end else if (y_off_r == Y_MAX_C) begin
                        y_off_s = y_off_r - 6'd1;
                        state_s = UP;
                    end else begin
                        y_off_s = y_off_r + 6'd1;
                    end
                end
                UP: begin
                    if (y_off_r == 6'd0) begin
                        y_off_s = 6'd1;
                        state_s = DOWN;
                    end else begin
                        y_off_s = y_off_r - 6'd1;
                    end
                end
                default: begin
                    y_off_s = 6'd0;
                    state_s = DOWN;
                end
            endcase
        end else begin
            scroll_x_s = scroll_x_r;
        end
    end

    // Pixel path: band membership against the currently held offsets.
    always_comb begin
        cell_x_s   = bus.hpos[8:3];
        cell_y_s   = bus.vpos[8:3];
        rel_s      = {1'b0, cell_y_s} - {1'b0, y_off_r};
        inside_s   = bus.pix_valid && (cell_y_s >= y_off_r) && (rel_s < BAND_H_C);
        x_out_s    = 6'd0;
        y_out_s    = 5'd0;
        layer_en_s = 1'b0;
        if (inside_s) begin
            x_out_s    = cell_x_s + scroll_x_r;
            y_out_s    = rel_s[4:0];
            layer_en_s = 1'b1;
        end else begin
            layer_en_s = 1'b0;
        end
    end

    // State and output registers; reset overrides both update paths.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= DOWN;
            y_off_r    <= 6'd0;
            scroll_x_r <= 6'd0;
            x_out_r    <= 6'd0;
            y_out_r    <= 5'd0;
            layer_en_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            y_off_r    <= y_off_s;
            scroll_x_r <= scroll_x_s;
            x_out_r    <= x_out_s;
            y_out_r    <= y_out_s;
            layer_en_r <= layer_en_s;
        end
    end

    assign bus.x_out    = x_out_r;
    assign bus.y_out    = y_out_r;
    assign bus.layer_en = layer_en_r;
    assign bus.scroll_x = scroll_x_r;
    assign bus.dir_up   = (state_r == UP);
endmodule

// File: tb/tb_sine_scroll_ctrl.sv
// Directed bench for sine_scroll_ctrl: default Y_MAX instance plus a Y_MAX=0 instance.
module tb_sine_scroll_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    sine_scroll_if bus ();
    sine_scroll_if bus0 ();

    sine_scroll_ctrl #(.Y_MAX(38)) dut  (.clk(clk), .rst(rst), .bus(bus));
    sine_scroll_ctrl #(.Y_MAX(0))  dut0 (.clk(clk), .rst(rst), .bus(bus0));

    assign bus0.frame_start = bus.frame_start;
    assign bus0.pix_valid   = bus.pix_valid;
    assign bus0.hpos        = bus.hpos;
    assign bus0.vpos        = bus.vpos;
    assign bus0.pause       = bus.pause;
    assign bus0.speed       = bus.speed;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_start = 1'b1;
            tick();
        end
        bus.frame_start = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Places the pixel three cells below the expected band top; y_out must read 3.
    task automatic check_band(input int yoff, input logic exp_dir, input string tag);
        bus.pix_valid = 1'b1;
        bus.hpos      = 10'd0;
        bus.vpos      = 10'((yoff + 3) * 8);
        tick();
        chk({tag, "_y"},   32'(bus.y_out),    32'd3);
        chk({tag, "_en"},  32'(bus.layer_en), 32'd1);
        chk({tag, "_dir"}, 32'(bus.dir_up),   32'(exp_dir));
    endtask

    initial begin
        rst             = 1'b1;
        bus.frame_start = 1'b0;
        bus.pix_valid   = 1'b1;
        bus.hpos        = 10'd16;
        bus.vpos        = 10'd40;
        bus.pause       = 1'b0;
        bus.speed       = 2'd0;
        tick();
        tick();
        chk("rst_x",     32'(bus.x_out),    32'd0);
        chk("rst_y",     32'(bus.y_out),    32'd0);
        chk("rst_en",    32'(bus.layer_en), 32'd0);
        chk("rst_sx",    32'(bus.scroll_x), 32'd0);
        chk("rst_dir",   32'(bus.dir_up),   32'd0);

        rst = 1'b0;
        tick();
        chk("first_x",   32'(bus.x_out),    32'd2);
        chk("first_y",   32'(bus.y_out),    32'd5);
        chk("first_en",  32'(bus.layer_en), 32'd1);

        // 22 frames at speed 3: scroll 66 mod 64 = 2, band top at cell 22
        bus.speed = 2'd3;
        pulses(22);
        bus.hpos = 10'd504;
        bus.vpos = 10'd176;
        tick();
        chk("scroll_sx", 32'(bus.scroll_x), 32'd2);
        chk("scroll_x",  32'(bus.x_out),    32'd1);
        chk("scroll_y",  32'(bus.y_out),    32'd0);
        chk("scroll_en", 32'(bus.layer_en), 32'd1);
        chk("y0_dir",    32'(bus0.dir_up),  32'd0);
        chk("y0_sx",     32'(bus0.scroll_x), 32'd2);
        chk("y0_en",     32'(bus0.layer_en), 32'd0);

        // Bounce: 39 frames total reach the turn, 37 more hit the top, 1 turns back
        bus.speed = 2'd0;
        pulses(17);
        check_band(37, 1'b1, "bounce39");
        pulses(37);
        check_band(0, 1'b1, "bounce76");
        pulses(1);
        check_band(1, 1'b0, "bounce77");

        // Paused frames freeze animation while the pixel path keeps running
        bus.pause = 1'b1;
        bus.speed = 2'd3;
        bus.hpos  = 10'd80;
        bus.vpos  = 10'd32;
        pulses(10);
        tick();
        chk("pause_sx",  32'(bus.scroll_x), 32'd2);
        chk("pause_x",   32'(bus.x_out),    32'd12);
        chk("pause_y",   32'(bus.y_out),    32'd3);
        check_band(1, 1'b0, "pause_band");

        // Band edges with y_off = 5
        bus.pause = 1'b0;
        bus.speed = 2'd0;
        pulses(4);
        bus.hpos = 10'd80;
        bus.vpos = 10'd32;
        tick();
        chk("above_en",  32'(bus.layer_en), 32'd0);
        chk("above_x",   32'(bus.x_out),    32'd0);
        chk("above_y",   32'(bus.y_out),    32'd0);
        chk("y0_above_y",  32'(bus0.y_out),    32'd4);
        chk("y0_above_en", 32'(bus0.layer_en), 32'd1);
        bus.vpos = 10'd216;
        tick();
        chk("below_en",  32'(bus.layer_en), 32'd0);
        bus.hpos = 10'd592;
        bus.vpos = 10'd720;
        tick();
        chk("last_y",    32'(bus.y_out),    32'd21);
        chk("last_x",    32'(bus.x_out),    32'd12);
        chk("last_en",   32'(bus.layer_en), 32'd1);
        bus.pix_valid = 1'b0;
        tick();
        chk("blank_x",   32'(bus.x_out),    32'd0);
        chk("blank_y",   32'(bus.y_out),    32'd0);
        chk("blank_en",  32'(bus.layer_en), 32'd0);

        // Pixel coinciding with an update sees pre-update scroll 8 / y_off 8
        bus.pix_valid = 1'b1;
        bus.speed     = 2'd2;
        pulses(3);
        bus.hpos        = 10'd0;
        bus.vpos        = 10'd88;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("coinc_x",   32'(bus.x_out),    32'd8);
        chk("coinc_y",   32'(bus.y_out),    32'd3);
        chk("coinc_sx",  32'(bus.scroll_x), 32'd10);

        // Reset wins over a simultaneous frame_start
        rst             = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        chk("rstfs_sx",  32'(bus.scroll_x), 32'd0);
        chk("rstfs_dir", 32'(bus.dir_up),   32'd0);
        chk("rstfs_en",  32'(bus.layer_en), 32'd0);
        chk("rstfs_x",   32'(bus.x_out),    32'd0);
        rst             = 1'b0;
        bus.frame_start = 1'b0;
        bus.hpos        = 10'd16;
        bus.vpos        = 10'd0;
        tick();
        chk("post_x",    32'(bus.x_out),    32'd2);
        chk("post_y",    32'(bus.y_out),    32'd0);
        chk("post_en",   32'(bus.layer_en), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
